// File: rtl/score_display_if.sv
// Control and display signals between the game FSM / board pins and score_display.
// master = the game side that issues requests; slave = the score_display block.
interface score_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    ena;
    logic                    invert;
    logic                    clr;
    logic                    inc;
    logic                    dec;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_value;
    logic                    blank_lz;
    logic                    blink;
    logic [4*NUM_DIGITS-1:0] value;
    logic                    overflow;
    logic [6:0]              segments;
    logic [NUM_DIGITS-1:0]   digits;

    modport master (
        output ena, invert, clr, inc, dec, load, load_value, blank_lz, blink,
        input  value, overflow, segments, digits
    );

    modport slave (
        input  ena, invert, clr, inc, dec, load, load_value, blank_lz, blink,
        output value, overflow, segments, digits
    );
endinterface

// File: rtl/score_display.sv
// NUM_DIGITS-wide BCD score counter driving a time-multiplexed 7-segment display
// with leading-zero blanking, blink and selectable segment/digit polarity.
module score_display #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 16,
    parameter bit WRAP         = 1'b1,
    parameter int BLINK_FRAMES = 32
) (
    input logic         clk,
    input logic         rst_n,
    score_display_if.slave bus
);
    localparam int VW    = 4 * NUM_DIGITS;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [VW-1:0]         value_q, value_d;
    logic                  overflow_q, overflow_d;
    logic [6:0]            segments_q, segments_d;
    logic [NUM_DIGITS-1:0] digits_q, digits_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FRM_W-1:0]      frm_q, frm_d;
    logic                  phase_q, phase_d;

    logic [VW-1:0] inc_val, dec_val;
    logic          inc_carry, dec_borrow;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    // Ripple BCD add/subtract; the final carry/borrow flags the all-9s / all-0s case.
    always_comb begin
        inc_val    = value_q;
        dec_val    = value_q;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (inc_carry) begin
                if (value_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (value_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        value_d    = value_q;
        overflow_d = 1'b0;
        if (bus.clr) begin
            value_d = '0;
        end else if (bus.load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                value_d[4*i +: 4] = (bus.load_value[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_value[4*i +: 4];
            end
        end else if (!(bus.inc && bus.dec)) begin
            if (bus.inc) begin
                overflow_d = inc_carry;
                value_d    = (inc_carry && !WRAP) ? value_q : inc_val;
            end else if (bus.dec) begin
                overflow_d = dec_borrow;
                value_d    = (dec_borrow && !WRAP) ? value_q : dec_val;
            end
        end
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        frm_d   = frm_q;
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                if (frm_q == FRM_LAST) begin
                    frm_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    frm_d = frm_q + 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    logic [3:0]            nib;
    logic                  zero_above, lz_blank, blank;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] dig_raw;

    // Scan from the top digit down so zero_above tells whether all higher digits are zero.
    always_comb begin
        nib        = 4'd0;
        lz_blank   = 1'b0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (IDX_W'(i) == idx_q) begin
                nib      = value_q[4*i +: 4];
                lz_blank = (i != 0) && zero_above && (value_q[4*i +: 4] == 4'd0);
            end
            zero_above = zero_above && (value_q[4*i +: 4] == 4'd0);
        end
        blank          = !bus.ena || (bus.blink && phase_q) || (bus.blank_lz && lz_blank);
        seg_raw        = blank ? 7'b0000000 : seg7(nib);
        dig_raw        = '0;
        dig_raw[idx_q] = 1'b1;
        segments_d     = bus.invert ? ~seg_raw : seg_raw;
        digits_d       = bus.invert ? ~dig_raw : dig_raw;
    end

    // NOTE: reset clears every register, including the display pins, so the board sees all-off.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q    <= '0;
            overflow_q <= 1'b0;
            segments_q <= '0;
            digits_q   <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            frm_q      <= '0;
            phase_q    <= 1'b0;
        end else begin
            value_q    <= value_d;
            overflow_q <= overflow_d;
            segments_q <= segments_d;
            digits_q   <= digits_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            frm_q      <= frm_d;
            phase_q    <= phase_d;
        end
    end

    assign bus.value    = value_q;
    assign bus.overflow = overflow_q;
    assign bus.segments = segments_q;
    assign bus.digits   = digits_q;
endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: one wrapping and one saturating instance share
// stimulus; an integer-arithmetic model predicts every registered output.
module tb_score_display;
    localparam int N    = 4;
    localparam int R    = 4;
    localparam int BF   = 2;
    localparam int VMAX = 9999;
    localparam logic [6:0] SEG [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                        7'b1111111, 7'b1101111};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ena, invert, clr, inc, dec, load, blank_lz, blink;
    logic [15:0] load_value;

    score_display_if #(.NUM_DIGITS(N)) bw ();
    score_display_if #(.NUM_DIGITS(N)) bs ();

    assign bw.ena = ena;  assign bw.invert = invert;  assign bw.clr = clr;
    assign bw.inc = inc;  assign bw.dec = dec;        assign bw.load = load;
    assign bw.load_value = load_value;  assign bw.blank_lz = blank_lz;  assign bw.blink = blink;
    assign bs.ena = ena;  assign bs.invert = invert;  assign bs.clr = clr;
    assign bs.inc = inc;  assign bs.dec = dec;        assign bs.load = load;
    assign bs.load_value = load_value;  assign bs.blank_lz = blank_lz;  assign bs.blink = blink;

    score_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .WRAP(1'b1), .BLINK_FRAMES(BF))
        dut_w (.clk(clk), .rst_n(rst_n), .bus(bw));
    score_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .WRAP(1'b0), .BLINK_FRAMES(BF))
        dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));

    typedef struct {
        logic [15:0] vw, vs;
        logic        ow, os;
        logic [6:0]  sw, ss;
        logic [3:0]  dg;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mv_w, mv_s, m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic int bcd_to_int(input logic [15:0] b);
        int r = 0;
        for (int i = 0; i < N; i++) begin
            int n = int'(b[4*i +: 4]);
            if (n > 9) n = 9;
            r += n * pow10(i);
        end
        return r;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int score_next(input int v, input bit wrap, output bit ov);
        ov = 1'b0;
        if (clr) return 0;
        if (load) return bcd_to_int(load_value);
        if (inc && dec) return v;
        if (inc) begin
            if (v == VMAX) begin ov = 1'b1; return wrap ? 0 : VMAX; end
            return v + 1;
        end
        if (dec) begin
            if (v == 0) begin ov = 1'b1; return wrap ? VMAX : 0; end
            return v - 1;
        end
        return v;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int idx, input bit phase);
        bit         blank = !ena || (blink && phase) || (blank_lz && idx != 0 && v < pow10(idx));
        logic [6:0] s     = blank ? 7'b0000000 : SEG[(v / pow10(idx)) % 10];
        return invert ? ~s : s;
    endfunction

    // Called at a falling edge: drives requests, predicts the next rising edge, waits a cycle.
    task automatic step(input bit c, input bit i, input bit d, input bit l, input logic [15:0] lv);
        exp_t       e;
        int         idx   = (m / R) % N;
        bit         phase = ((m / (R * N * BF)) % 2) == 1;
        logic [3:0] oh    = 4'b0001 << idx;
        clr = c; inc = i; dec = d; load = l; load_value = lv;
        e.dg = invert ? ~oh : oh;
        e.sw = exp_seg(mv_w, idx, phase);
        e.ss = exp_seg(mv_s, idx, phase);
        mv_w = score_next(mv_w, 1'b1, e.ow);
        mv_s = score_next(mv_s, 1'b0, e.os);
        e.vw = int_to_bcd(mv_w);
        e.vs = int_to_bcd(mv_s);
        q.push_back(e);
        m++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 16'h0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_value_w"}, 32'(bw.value), 0);
        check({tag, "_value_s"}, 32'(bs.value), 0);
        check({tag, "_ovf_w"}, 32'(bw.overflow), 0);
        check({tag, "_seg_w"}, 32'(bw.segments), 0);
        check({tag, "_seg_s"}, 32'(bs.segments), 0);
        check({tag, "_dig_w"}, 32'(bw.digits), 0);
        check({tag, "_dig_s"}, 32'(bs.digits), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("value_wrap", 32'(bw.value), 32'(e.vw));
                check("value_sat", 32'(bs.value), 32'(e.vs));
                check("overflow_wrap", 32'(bw.overflow), 32'(e.ow));
                check("overflow_sat", 32'(bs.overflow), 32'(e.os));
                check("segments_wrap", 32'(bw.segments), 32'(e.sw));
                check("segments_sat", 32'(bs.segments), 32'(e.ss));
                check("digits_wrap", 32'(bw.digits), 32'(e.dg));
                check("digits_sat", 32'(bs.digits), 32'(e.dg));
            end
        end
    end

    initial begin : stimulus
        ena = 1; invert = 0; blank_lz = 1; blink = 0;
        clr = 0; inc = 0; dec = 0; load = 0; load_value = '0;
        mv_w = 0; mv_s = 0; m = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0, 16'h0);
            step(0, 0, 0, 0, 16'h0);
        end
        idle(2 * R * N);
        step(0, 0, 0, 1, 16'h9998); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); idle(3);
        step(1, 0, 0, 0, 0); step(0, 0, 1, 0, 0); idle(2);
        step(0, 0, 0, 1, 16'h1000); step(0, 0, 1, 0, 0); idle(2);
        step(0, 1, 1, 0, 0); step(1, 1, 0, 0, 0); step(0, 0, 0, 1, 16'hA5F3); idle(R * N);

        invert = 1; blank_lz = 0;
        step(0, 0, 0, 1, 16'h0008); idle(2 * R * N);
        invert = 0; blink = 1; blank_lz = 1;
        idle(5 * R * N * BF);

        // Asynchronous reset between clock edges, part way through a frame.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(posedge clk);
        #1 check_zero("held_reset");
        @(negedge clk);
        mv_w = 0; mv_s = 0; m = 0;
        rst_n = 1'b1;
        blink = 0;

        for (int k = 0; k < 1500; k++) begin
            int op = int'($urandom_range(0, 15));
            logic [15:0] lv;
            if (k % 50 == 0) begin
                ena      = ($urandom_range(0, 9) != 0);
                invert   = $urandom_range(0, 1) == 1;
                blank_lz = $urandom_range(0, 1) == 1;
                blink    = $urandom_range(0, 3) == 0;
            end
            case ($urandom_range(0, 3))
                0:       lv = 16'h9999;
                1:       lv = 16'h0000;
                default: lv = 16'($urandom);
            endcase
            if (op == 0)                 step(1, 0, 0, 0, 0);
            else if (op <= 2)            step(0, 0, 0, 1, lv);
            else if (op <= 7)            step(0, 1, 0, 0, 0);
            else if (op <= 10)           step(0, 0, 1, 0, 0);
            else if (op == 11)           step(0, 1, 1, 0, 0);
            else                         step(0, 0, 0, 0, 0);
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
